// File: rtl/pcecd_pkg.sv
// Shared definitions for the PCE CD SCSI target sequencer: phase codes,
// bus-bit masks, CDB length decode and common status/message values.
package pcecd_pkg;

  typedef enum logic [2:0] {
    PH_BUS_FREE = 3'd0,
    PH_COMMAND  = 3'd1,
    PH_EXEC     = 3'd2,
    PH_DATA_IN  = 3'd3,
    PH_STATUS   = 3'd4,
    PH_MSG_IN   = 3'd5
  } phase_e;

  // Bit positions match $1800[7:3] = {BSY, REQ, MSG, CD, IO}.
  localparam logic [4:0] BUS_BSY = 5'b10000;
  localparam logic [4:0] BUS_REQ = 5'b01000;
  localparam logic [4:0] BUS_MSG = 5'b00100;
  localparam logic [4:0] BUS_CD  = 5'b00010;
  localparam logic [4:0] BUS_IO  = 5'b00001;

  localparam logic [7:0] STATUS_GOOD      = 8'h00;
  localparam logic [7:0] STATUS_CHECK     = 8'h02;
  localparam logic [7:0] MSG_CMD_COMPLETE = 8'h00;

  // Static bus levels (everything except REQ) driven in each phase.
  function automatic logic [4:0] phase_bus(phase_e ph);
    logic [4:0] b;
    case (ph)
      PH_COMMAND: b = BUS_BSY | BUS_CD;
      PH_EXEC:    b = BUS_BSY;
      PH_DATA_IN: b = BUS_BSY | BUS_IO;
      PH_STATUS:  b = BUS_BSY | BUS_CD | BUS_IO;
      PH_MSG_IN:  b = BUS_BSY | BUS_MSG | BUS_CD | BUS_IO;
      default:    b = 5'b00000;
    endcase
    return b;
  endfunction

  // CDB length from the opcode group code (opcode[7:5]), clamped to the buffer.
  function automatic logic [3:0] cdb_len(logic [2:0] grp, logic [3:0] max_len);
    logic [3:0] l;
    case (grp)
      3'd1, 3'd2: l = 4'd10;
      3'd5:       l = 4'd12;
      default:    l = 4'd6;
    endcase
    if (l > max_len) l = max_len;
    return l;
  endfunction

endpackage

// File: rtl/pcecd_scsi_seq_if.sv
// SCSI bus between the $1800-$1804 register file (initiator, master) and the
// target-side phase sequencer (slave).
//
// Handshake: the target raises req only while ack is low; a byte moves on the
// cycle req && ack is seen; the target then drops req, and the next byte may
// start only once ack has been seen low again. An ack still high from a
// previous phase therefore never counts as a transfer.
interface pcecd_scsi_seq_if;
  logic       scsi_sel;
  logic       scsi_rst;
  logic       scsi_ack;
  logic [7:0] db_in;
  logic       bsy;
  logic       req;
  logic       msg;
  logic       cd;
  logic       io;
  logic [7:0] db_out;
  logic [2:0] phase;

  modport master (
    output scsi_sel, scsi_rst, scsi_ack, db_in,
    input  bsy, req, msg, cd, io, db_out, phase
  );

  modport slave (
    input  scsi_sel, scsi_rst, scsi_ack, db_in,
    output bsy, req, msg, cd, io, db_out, phase
  );
endinterface

// File: rtl/pcecd_scsi_cmdbuf.sv
// CDB collection buffer: bytes are appended at the write counter, any entry
// can be read combinationally, and the opcode group is exported for length decode.
module pcecd_scsi_cmdbuf #(
  parameter int CMD_MAX = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       wr_i,
  input  logic [7:0] wr_data_i,
  input  logic [3:0] rd_idx_i,
  output logic [7:0] rd_data_o,
  output logic [2:0] first_grp_o,
  output logic [3:0] cnt_o
);
  localparam logic [3:0] MAX_LEN = 4'(CMD_MAX);

  logic [7:0] mem_q [CMD_MAX];
  logic [3:0] cnt_q;
  logic       wr_ok;

  assign wr_ok = wr_i && !clr_i && (cnt_q < MAX_LEN);

  // Write counter: cleared on reset or at the start of every command phase.
  always_ff @(posedge clk) begin
    if (reset || clr_i) cnt_q <= 4'd0;
    else if (wr_ok)     cnt_q <= cnt_q + 4'd1;
  end

  // Byte storage; contents are only meaningful below the counter.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[cnt_q] <= wr_data_i;
  end

  assign rd_data_o   = (rd_idx_i < MAX_LEN) ? mem_q[rd_idx_i] : 8'h00;
  assign first_grp_o = mem_q[0][7:5];
  assign cnt_o       = cnt_q;
endmodule

// File: rtl/pcecd_scsi_seq.sv
// Target-side SCSI phase sequencer: collects the CDB, hands it to the drive
// model, streams drive data, then returns status and message bytes.
module pcecd_scsi_seq
  import pcecd_pkg::*;
#(
  parameter int CMD_MAX = 12
) (
  input  logic             clk,
  input  logic             reset,
  pcecd_scsi_seq_if.slave  bus,
  output logic             cmd_done,
  output logic [3:0]       cmd_len,
  output logic [7:0]       cmd_byte,
  input  logic [3:0]       cmd_idx,
  input  logic             data_start,
  input  logic             data_valid,
  input  logic [7:0]       data_byte,
  input  logic             data_last,
  output logic             data_pop,
  input  logic             status_valid,
  input  logic [7:0]       status_byte,
  input  logic [7:0]       msg_byte,
  output logic             irq_xfer_ready,
  output logic             irq_xfer_done
);
  localparam logic [3:0] MAX_LEN = 4'(CMD_MAX);

  phase_e     phase_q;
  logic       req_q, sel_q, pend_q, last_q, xfer_q;
  logic [7:0] db_out_q, stat_q, msg_q;
  logic [3:0] cmd_len_q, cnt, cur_len;
  logic [2:0] grp;
  logic       cmd_done_q, data_pop_q, rdy_q, done_q;
  logic       sel_rise, buf_wr, buf_clr;
  logic [4:0] bus_bits;

  assign sel_rise = bus.scsi_sel && !sel_q;
  assign buf_wr   = (phase_q == PH_COMMAND) && req_q && bus.scsi_ack && !bus.scsi_rst;
  assign buf_clr  = bus.scsi_rst || ((phase_q == PH_BUS_FREE) && sel_rise);
  assign cur_len  = cdb_len(grp, MAX_LEN);

  pcecd_scsi_cmdbuf #(.CMD_MAX(CMD_MAX)) u_cmdbuf (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (buf_clr),
    .wr_i       (buf_wr),
    .wr_data_i  (bus.db_in),
    .rd_idx_i   (cmd_idx),
    .rd_data_o  (cmd_byte),
    .first_grp_o(grp),
    .cnt_o      (cnt)
  );

  // Phase sequencer with registered REQ, data byte, latched status and pulses.
  always_ff @(posedge clk) begin
    if (reset || bus.scsi_rst) begin
      phase_q    <= PH_BUS_FREE;
      req_q      <= 1'b0;
      sel_q      <= 1'b0;
      pend_q     <= 1'b0;
      last_q     <= 1'b0;
      xfer_q     <= 1'b0;
      db_out_q   <= 8'h00;
      stat_q     <= 8'h00;
      msg_q      <= 8'h00;
      cmd_len_q  <= 4'd0;
      cmd_done_q <= 1'b0;
      data_pop_q <= 1'b0;
      rdy_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sel_q      <= bus.scsi_sel;
      cmd_done_q <= 1'b0;
      data_pop_q <= 1'b0;
      rdy_q      <= 1'b0;
      done_q     <= 1'b0;
      case (phase_q)
        PH_BUS_FREE: begin
          if (sel_rise) begin
            phase_q <= PH_COMMAND;
            req_q   <= 1'b0;
          end
        end
        PH_COMMAND: begin
          if (req_q && bus.scsi_ack) begin
            req_q <= 1'b0;
          end else if (!req_q && !bus.scsi_ack) begin
            if ((cnt != 4'd0) && (cnt == cur_len)) begin
              phase_q    <= PH_EXEC;
              cmd_done_q <= 1'b1;
              cmd_len_q  <= cnt;
            end else begin
              req_q <= 1'b1;
            end
          end
        end
        PH_EXEC: begin
          if (data_start) begin
            phase_q <= PH_DATA_IN;
            rdy_q   <= 1'b1;
            last_q  <= 1'b0;
            // Status arriving alongside the data request waits its turn.
            if (status_valid) begin
              pend_q <= 1'b1;
              stat_q <= status_byte;
              msg_q  <= msg_byte;
            end
          end else if (status_valid) begin
            phase_q <= PH_STATUS;
            xfer_q  <= 1'b0;
            stat_q  <= status_byte;
            msg_q   <= msg_byte;
          end
        end
        PH_DATA_IN: begin
          if (status_valid && !pend_q) begin
            pend_q <= 1'b1;
            stat_q <= status_byte;
            msg_q  <= msg_byte;
          end
          if (req_q && bus.scsi_ack) begin
            req_q <= 1'b0;
          end else if (!req_q && !bus.scsi_ack) begin
            if (last_q) begin
              if (pend_q) begin
                phase_q <= PH_STATUS;
                pend_q  <= 1'b0;
                xfer_q  <= 1'b0;
              end
            end else if (data_valid) begin
              db_out_q   <= data_byte;
              data_pop_q <= 1'b1;
              req_q      <= 1'b1;
              last_q     <= data_last;
            end
          end
        end
        PH_STATUS, PH_MSG_IN: begin
          if (req_q && bus.scsi_ack) begin
            req_q  <= 1'b0;
            xfer_q <= 1'b1;
          end else if (!req_q && !bus.scsi_ack) begin
            if (xfer_q) begin
              xfer_q <= 1'b0;
              if (phase_q == PH_STATUS) begin
                phase_q <= PH_MSG_IN;
              end else begin
                phase_q <= PH_BUS_FREE;
                done_q  <= 1'b1;
              end
            end else begin
              db_out_q <= (phase_q == PH_STATUS) ? stat_q : msg_q;
              req_q    <= 1'b1;
            end
          end
        end
        default: phase_q <= PH_BUS_FREE;
      endcase
    end
  end

  assign bus_bits       = phase_bus(phase_q) | (req_q ? BUS_REQ : 5'b00000);
  assign bus.bsy        = bus_bits[4];
  assign bus.req        = bus_bits[3];
  assign bus.msg        = bus_bits[2];
  assign bus.cd         = bus_bits[1];
  assign bus.io         = bus_bits[0];
  assign bus.db_out     = db_out_q;
  assign bus.phase      = phase_q;
  assign cmd_done       = cmd_done_q;
  assign cmd_len        = cmd_len_q;
  assign data_pop       = data_pop_q;
  assign irq_xfer_ready = rdy_q;
  assign irq_xfer_done  = done_q;
endmodule

// File: tb/tb_pcecd_scsi_seq.sv
// Bench for the PCE CD SCSI target sequencer: initiator/drive driver tasks,
// an event scoreboard fed by a transaction-level model, and a final report.
`timescale 1ns/1ps
module tb_pcecd_scsi_seq;
  import pcecd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pcecd_scsi_seq_if bus();

  logic       cmd_done, data_pop, irq_xfer_ready, irq_xfer_done;
  logic [3:0] cmd_len, cmd_idx;
  logic [7:0] cmd_byte, data_byte, status_byte, msg_byte;
  logic       data_start, data_valid, data_last, status_valid;

  pcecd_scsi_seq #(.CMD_MAX(12)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cmd_done(cmd_done), .cmd_len(cmd_len), .cmd_byte(cmd_byte), .cmd_idx(cmd_idx),
    .data_start(data_start), .data_valid(data_valid), .data_byte(data_byte),
    .data_last(data_last), .data_pop(data_pop), .status_valid(status_valid),
    .status_byte(status_byte), .msg_byte(msg_byte),
    .irq_xfer_ready(irq_xfer_ready), .irq_xfer_done(irq_xfer_done)
  );

  // ---------------- scoreboard ----------------
  localparam logic [3:0] K_REQ = 4'h1, K_CMD = 4'h2, K_RDY = 4'h3, K_POP = 4'h4, K_DONE = 4'h5;
  localparam logic [3:0] B_CMD = 4'b1010, B_DATA = 4'b1001, B_STAT = 4'b1011, B_MSG = 4'b1111;

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] cdb [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic observe(input logic [15:0] ev);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL event: actual=%04h required=none (unexpected)", ev);
    end else begin
      e = exp_q.pop_front();
      check("event", {16'h0, ev}, {16'h0, e});
    end
  endtask

  // Monitor: turns DUT pulses and REQ rising edges into events.
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_done)       observe({K_CMD, 1'b0, bus.phase, 4'h0, cmd_len});
      if (irq_xfer_ready) observe({K_RDY, 1'b0, bus.phase, 8'h00});
      if (irq_xfer_done)  observe({K_DONE, 1'b0, bus.phase, 8'h00});
      if (data_pop)       observe({K_POP, 1'b0, bus.phase, bus.db_out});
      if (bus.req && !req_prev)
        observe({K_REQ, bus.bsy, bus.msg, bus.cd, bus.io, (bus.io ? bus.db_out : 8'h00)});
      req_prev = bus.req;
    end else begin
      req_prev = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  function automatic int ref_len(input logic [7:0] op);
    int l;
    case (op[7:5])
      3'd1, 3'd2: l = 10;
      3'd5:       l = 12;
      default:    l = 6;
    endcase
    return (l > 12) ? 12 : l;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input logic lvl, input string what);
    int t = 0;
    while (bus.req !== lvl && t < 400) begin @(negedge clk); t++; end
    if (bus.req !== lvl) begin
      n_checks++;
      $display("FAIL timeout_%s: req=%b required=%b", what, bus.req, lvl);
    end
  endtask

  task automatic wait_phase(input logic [2:0] p, input string what);
    int t = 0;
    while (bus.phase !== p && t < 400) begin @(negedge clk); t++; end
    if (bus.phase !== p) begin
      n_checks++;
      $display("FAIL timeout_%s: phase=%0d required=%0d", what, bus.phase, p);
    end
  endtask

  task automatic xfer_ack(input string what);
    wait_req(1'b1, what);
    step($urandom_range(0, 2));
    bus.scsi_ack = 1'b1;
    wait_req(1'b0, what);
    step($urandom_range(0, 2));
    bus.scsi_ack = 1'b0;
  endtask

  // Select, then hand over the first len bytes of cdb[].
  task automatic send_cmd(input int len);
    for (int i = 0; i < len; i++) exp_q.push_back({K_REQ, B_CMD, 8'h00});
    exp_q.push_back({K_CMD, 4'h2, 4'h0, 4'(len)});
    bus.scsi_sel = 1'b1;
    step(1);
    bus.scsi_sel = 1'b0;
    for (int i = 0; i < len; i++) begin
      bus.db_in = cdb[i];
      xfer_ack("cmd");
    end
    wait_phase(3'd2, "exec");
  endtask

  // n data bytes (0 = status only); mode 0: status with data_start,
  // 1: status during byte k, 2: status after the data.
  task automatic run_xfer(input int n, input int mode, input logic [7:0] st, input logic [7:0] mg);
    logic [7:0] d [8];
    int k;
    k = (n > 0) ? $urandom_range(0, n - 1) : 0;
    for (int i = 0; i < n; i++) d[i] = 8'($urandom_range(0, 255));
    if (n > 0) exp_q.push_back({K_RDY, 4'h3, 8'h00});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({K_POP, 4'h3, d[i]});
      exp_q.push_back({K_REQ, B_DATA, d[i]});
    end
    exp_q.push_back({K_REQ, B_STAT, st});
    exp_q.push_back({K_REQ, B_MSG, mg});
    exp_q.push_back({K_DONE, 4'h0, 8'h00});
    status_byte = st;
    msg_byte    = mg;
    step($urandom_range(0, 3));
    if (n == 0) begin
      status_valid = 1'b1; step(1); status_valid = 1'b0;
    end else begin
      data_start = 1'b1;
      status_valid = (mode == 0);
      step(1);
      data_start = 1'b0; status_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (mode == 1 && i == k) begin status_valid = 1'b1; step(1); status_valid = 1'b0; end
        step($urandom_range(0, 2));
        data_byte = d[i]; data_last = (i == n - 1); data_valid = 1'b1;
        wait_req(1'b1, "data");
        data_valid = 1'b0; data_last = 1'b0;
        xfer_ack("data");
      end
      if (mode == 2) begin
        step($urandom_range(0, 4));
        status_valid = 1'b1; step(1); status_valid = 1'b0;
      end
    end
    xfer_ack("status");
    xfer_ack("msg");
    wait_phase(3'd0, "busfree");
  endtask

  task automatic finish_report();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  initial begin
    #5_000_000;
    n_checks++;
    $display("FAIL watchdog: actual=running required=finished");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    bus.scsi_sel = 1'b0; bus.scsi_rst = 1'b0; bus.scsi_ack = 1'b0; bus.db_in = 8'h00;
    cmd_idx = 4'd0; data_start = 1'b0; data_valid = 1'b0; data_byte = 8'h00;
    data_last = 1'b0; status_valid = 1'b0; status_byte = 8'h00; msg_byte = 8'h00;
    step(3);
    reset = 1'b0;
    step(1);
    check("reset_phase", bus.phase, 0);
    check("reset_bus", {bus.bsy, bus.req, bus.msg, bus.cd, bus.io}, 0);
    check("reset_db_out", bus.db_out, 0);
    check("reset_pulses", {cmd_done, data_pop, irq_xfer_ready, irq_xfer_done, cmd_len}, 0);

    // 1: six-byte group-0 command.
    cdb[0] = 8'h08; cdb[1] = 8'h00; cdb[2] = 8'h00; cdb[3] = 8'h10; cdb[4] = 8'h01; cdb[5] = 8'h00;
    send_cmd(6);
    cmd_idx = 4'd3; #1;
    check("cmd_idx3", cmd_byte, 8'h10);
    check("exec_phase", bus.phase, 2);
    check("exec_bsy_req", {bus.bsy, bus.req}, 2'b10);

    // 3: four data bytes with status pending from data_start.
    begin
      exp_q.push_back({K_RDY, 4'h3, 8'h00});
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back({K_POP, 4'h3, 8'hAA + 8'(i * 17)});
        exp_q.push_back({K_REQ, B_DATA, 8'hAA + 8'(i * 17)});
      end
      exp_q.push_back({K_REQ, B_STAT, STATUS_GOOD});
      exp_q.push_back({K_REQ, B_MSG, MSG_CMD_COMPLETE});
      exp_q.push_back({K_DONE, 4'h0, 8'h00});
      status_byte = STATUS_GOOD; msg_byte = MSG_CMD_COMPLETE;
      data_start = 1'b1; status_valid = 1'b1; step(1);
      data_start = 1'b0; status_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        data_byte = 8'hAA + 8'(i * 17); data_last = (i == 3); data_valid = 1'b1;
        wait_req(1'b1, "data");
        data_valid = 1'b0; data_last = 1'b0;
        xfer_ack("data");
      end
      xfer_ack("status");
      xfer_ack("msg");
      wait_phase(3'd0, "busfree");
    end

    // 2: ten- and twelve-byte commands; 4: status-only completion.
    cdb[0] = 8'h28;
    for (int i = 1; i < 12; i++) cdb[i] = 8'(i * 3);
    send_cmd(10);
    run_xfer(2, 2, STATUS_GOOD, MSG_CMD_COMPLETE);
    cdb[0] = 8'hA8;
    send_cmd(12);
    cmd_idx = 4'd11; #1;
    check("cmd_idx11", cmd_byte, 8'd33);
    run_xfer(0, 0, STATUS_CHECK, MSG_CMD_COMPLETE);

    // 5: bus reset in DATA_IN after two bytes.
    cdb[0] = 8'h08;
    send_cmd(6);
    exp_q.push_back({K_RDY, 4'h3, 8'h00});
    exp_q.push_back({K_POP, 4'h3, 8'h11}); exp_q.push_back({K_REQ, B_DATA, 8'h11});
    exp_q.push_back({K_POP, 4'h3, 8'h22}); exp_q.push_back({K_REQ, B_DATA, 8'h22});
    data_start = 1'b1; step(1); data_start = 1'b0;
    data_byte = 8'h11; data_valid = 1'b1;
    wait_req(1'b1, "data");
    data_valid = 1'b0;
    xfer_ack("data");
    data_byte = 8'h22; data_valid = 1'b1;
    wait_req(1'b1, "data");
    data_byte = 8'h33;
    bus.scsi_ack = 1'b1;
    wait_req(1'b0, "data");
    bus.scsi_ack = 1'b0; bus.scsi_rst = 1'b1;
    step(1);
    bus.scsi_rst = 1'b0; data_valid = 1'b0;
    check("rst_bus", {bus.bsy, bus.req, bus.msg, bus.cd, bus.io}, 0);
    check("rst_phase", bus.phase, 0);
    check("rst_db_out", bus.db_out, 0);
    step(4);
    check("rst_idle", bus.phase, 0);
    check("rst_queue", exp_q.size(), 0);
    for (int i = 0; i < 6; i++) cdb[i] = 8'h40 + 8'(i);
    cdb[0] = 8'h00;
    send_cmd(6);
    for (int i = 0; i < 6; i++) begin
      cmd_idx = 4'(i); #1;
      check("restart_cdb", cmd_byte, cdb[i]);
    end
    run_xfer(0, 0, STATUS_GOOD, MSG_CMD_COMPLETE);

    // 6: SEL ignored in STATUS; ack held high across MSG_IN entry.
    send_cmd(6);
    exp_q.push_back({K_REQ, B_STAT, STATUS_CHECK});
    exp_q.push_back({K_REQ, B_MSG, 8'h5A});
    exp_q.push_back({K_DONE, 4'h0, 8'h00});
    status_byte = STATUS_CHECK; msg_byte = 8'h5A;
    status_valid = 1'b1; step(1); status_valid = 1'b0;
    wait_req(1'b1, "status");
    bus.scsi_sel = 1'b1; step(1); bus.scsi_sel = 1'b0; step(1);
    check("sel_ignored", bus.phase, 4);
    bus.scsi_ack = 1'b1;
    wait_req(1'b0, "status");
    bus.scsi_ack = 1'b0; step(1);
    bus.scsi_ack = 1'b1; step(1);
    check("msg_entry", bus.phase, 5);
    step(4);
    check("msg_held", {bus.phase, bus.req}, {3'd5, 1'b0});
    bus.scsi_ack = 1'b0;
    xfer_ack("msg");
    wait_phase(3'd0, "busfree");
    step(3);
    check("stay_free", bus.phase, 0);

    // Randomized transactions against the model.
    for (int t = 0; t < 16; t++) begin
      int len;
      cdb[0] = 8'($urandom_range(0, 255));
      for (int i = 1; i < 12; i++) cdb[i] = 8'($urandom_range(0, 255));
      len = ref_len(cdb[0]);
      step($urandom_range(0, 3));
      send_cmd(len);
      cmd_idx = 4'($urandom_range(0, len - 1)); #1;
      check("rand_cdb", cmd_byte, cdb[cmd_idx]);
      run_xfer($urandom_range(0, 5), $urandom_range(0, 2),
               ($urandom_range(0, 1) != 0) ? STATUS_CHECK : STATUS_GOOD,
               8'($urandom_range(0, 255)));
    end

    step(5);
    check("queue_drained", exp_q.size(), 0);
    finish_report();
  end
endmodule

// File: doc/pcecd_scsi_seq.md
Name: pcecd_scsi_seq

Overview:
Target-side SCSI bus phase sequencer for the PCE CD interface.
- Owns BSY/REQ/MSG/CD/IO and the target-driven data byte.
- Runs the REQ/ACK byte handshake in every phase.
- Collects command descriptor blocks (CDBs) and hands each one to the drive model.
- Returns drive data, then the status and message bytes.
- Sits between the $1800–$1804 register file (which supplies SEL, ACK, RST and initiator bytes) and the drive/sector-buffer logic.

Parameters:
- CMD_MAX, 12, size of the CDB buffer in bytes; longest supported CDB.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- scsi_sel  in  1  initiator SEL level
- scsi_rst  in  1  initiator RST level (bus reset)
- scsi_ack  in  1  initiator ACK level
- db_in  in  8  initiator data byte (last $1801 write)
- bsy, req, msg, cd, io  out  1 each  target bus signals, feed $1800[7:3]
- db_out  out  8  target data byte, readable at $1801
- phase  out  3  current phase code
- cmd_done  out  1  one-cycle pulse: CDB complete
- cmd_len  out  4  CDB byte count, valid with cmd_done
- cmd_byte  out  8  cmd buffer read data
- cmd_idx  in  4  cmd buffer read index (combinational read)
- data_start  in  1  drive: enter DATA_IN
- data_valid  in  1  drive: data_byte available
- data_byte  in  8  drive data byte
- data_last  in  1  qualifies data_byte as final byte
- data_pop  out  1  one-cycle pulse: data_byte consumed
- status_valid  in  1  drive: status/message available
- status_byte  in  8  status byte
- msg_byte  in  8  message byte
- irq_xfer_ready  out  1  pulse on entering DATA_IN
- irq_xfer_done  out  1  pulse on MSG_IN → BUS_FREE

Behaviour:
Reset and bus reset:
- reset, or scsi_rst high in any state (priority over all other inputs): next cycle phase=BUS_FREE.
- All outputs 0, db_out=0, command counter=0, pending status cleared.
- No irq pulses are generated.

Phase codes: BUS_FREE=0, COMMAND=1, EXEC=2, DATA_IN=3, STATUS=4, MSG_IN=5.

Bus signals per phase:
- BUS_FREE: all 0.
- COMMAND: bsy, cd.
- EXEC: bsy.
- DATA_IN: bsy, io.
- STATUS: bsy, cd, io.
- MSG_IN: bsy, msg, cd, io.

Transitions:
- BUS_FREE → COMMAND: on scsi_sel rising edge. The registered previous value resets to 0. SEL in any other state is ignored.
- COMMAND:
  - req rises the cycle after phase entry.
  - When req&&ack: write db_in to buf[cnt], cnt++, req←0.
  - When !req&&!ack: if cnt==len → EXEC, else req←1.
  - len is decoded from buf[0][7:5]: 0→6, 1/2→10, 5→12, other→6. len is clamped to CMD_MAX.
- EXEC:
  - cmd_done pulses on the first cycle of EXEC, with cmd_len.
  - data_start → DATA_IN.
  - status_valid → STATUS, latching status_byte and msg_byte.
  - If both arrive in the same cycle, data_start wins and the status is latched as pending.
- DATA_IN:
  - While !req&&!ack&&data_valid: db_out←data_byte, data_pop pulses, req←1, and data_last is recorded.
  - When req&&ack: req←0.
  - After the last byte's ACK falls: STATUS if a status is pending, else wait for status_valid.
  - status_valid arriving during DATA_IN is latched.
  - data_valid low simply stalls the transfer; there is no timeout.
- STATUS:
  - db_out←status, req←1.
  - On req&&ack: req←0.
  - When !ack: → MSG_IN.
- MSG_IN:
  - db_out←msg, req←1.
  - Same handshake as STATUS.
  - Then → BUS_FREE with an irq_xfer_done pulse.

Handshake rules:
- req only changes when ack is at the opposite level required by the rule.
- An ack held high across a phase change is not counted until it has been seen low.

Decomposition:
- Shared package pcecd_pkg: phase enum, bus-bit masks (BUSY/REQ/MSG/CD/IO), CDB-length decode function, SCSI status/message constants (STATUS_GOOD=0x00, CHECK=0x02).
- Sub-module pcecd_scsi_cmdbuf: CMD_MAX×8 buffer with write counter and combinational read port.

Test Plan:
1. SEL pulse, then 6 handshakes of bytes 08 00 00 10 01 00 → cmd_done once with cmd_len=6; cmd_idx=3 reads 0x10; phase=EXEC; bsy=1, req=0.
2. Opcode 0x28 → 10 bytes collected before EXEC; opcode 0xA8 → 12 bytes.
3. After EXEC, data_start; drive supplies 4 bytes AA BB CC DD (DD with data_last), plus status_valid 00/00 → 4 data_pop pulses, db_out sequence matches, then STATUS db_out=00, MSG_IN db_out=00, BUS_FREE, irq_xfer_done one pulse.
4. EXEC with status_valid only (status 02, msg 00) → STATUS→MSG_IN→BUS_FREE; no irq_xfer_ready; db_out=02 then 00.
5. scsi_rst asserted during DATA_IN after 2 bytes → next cycle all bus signals 0, phase=0, no irq_xfer_done; a new SEL restarts COMMAND with cnt=0.
6. SEL pulsed during STATUS, and ack held high into MSG_IN entry → SEL ignored; the MSG byte is not consumed until ack toggles low then high.
